bus_datapath: RTL and testbench



---
 rtl/bus_datapath_pkg.sv | 34 +++
 rtl/bus_datapath_reg32.sv | 24 ++
 rtl/bus_datapath.sv | 100 ++++++++++
 tb/tb_bus_datapath.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_datapath_pkg.sv
// Shared constants for the single-bus datapath: data width, the Rin/Rout
// index map and the position of the C-immediate field inside IR.
package bus_datapath_pkg;

    localparam int WIDTH     = 32;
    localparam int NUM_SEL   = 24;
    localparam int C_IMM_MSB = 18;

    localparam int IDX_R0     = 0;
    localparam int IDX_R1     = 1;
    localparam int IDX_R2     = 2;
    localparam int IDX_R3     = 3;
    localparam int IDX_R4     = 4;
    localparam int IDX_R5     = 5;
    localparam int IDX_R6     = 6;
    localparam int IDX_R7     = 7;
    localparam int IDX_R8     = 8;
    localparam int IDX_R9     = 9;
    localparam int IDX_R10    = 10;
    localparam int IDX_R11    = 11;
    localparam int IDX_R12    = 12;
    localparam int IDX_R13    = 13;
    localparam int IDX_R14    = 14;
    localparam int IDX_R15    = 15;
    localparam int IDX_HI     = 16;
    localparam int IDX_LO     = 17;
    localparam int IDX_ZHI    = 18;
    localparam int IDX_ZLO    = 19;
    localparam int IDX_PC     = 20;
    localparam int IDX_MDR    = 21;
    localparam int IDX_INPORT = 22;
    localparam int IDX_C      = 23;

endpackage

// File: rtl/bus_datapath_reg32.sv
// Generic datapath register: synchronous clear has priority over the load enable.
module reg32 #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] reg_q;

    always_ff @(posedge clock) begin
        if (clear) begin
            reg_q <= '0;
        end else if (en_i) begin
            reg_q <= d_i;
        end
    end

    assign q_o = reg_q;

endmodule

// File: rtl/bus_datapath.sv
// Single-bus 32-bit CPU datapath: bus-indexed register file, special
// registers and a zero-latency priority bus multiplexer.
module bus_datapath
    import bus_datapath_pkg::*;
#(
    parameter int WIDTH = bus_datapath_pkg::WIDTH
) (
    input  logic               clock,
    input  logic               clear,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [WIDTH-1:0]   Mdatain,
    input  logic [NUM_SEL-1:0] Rin,
    input  logic [NUM_SEL-1:0] Rout,
    input  logic               IRin,
    input  logic               MARin,
    input  logic               RAout,
    input  logic               RBout,
    input  logic               RCout,
    input  logic               RZout,
    input  logic               RYin,
    input  logic               RAin,
    input  logic               RBin,
    input  logic               RCin,
    input  logic               RZin,
    input  logic               MDRread,
    output logic [WIDTH-1:0]   BusMuxOut,
    output logic [WIDTH-1:0]   IRout,
    output logic [WIDTH-1:0]   MARout,
    output logic [WIDTH-1:0]   RYout
);

    logic [WIDTH-1:0] bus_mux;
    logic [WIDTH-1:0] src_q [NUM_SEL];
    logic [WIDTH-1:0] mdr_d;
    logic [WIDTH-1:0] ir_q;
    logic [WIDTH-1:0] mar_q;
    logic [WIDTH-1:0] ra_q;
    logic [WIDTH-1:0] rb_q;
    logic [WIDTH-1:0] rc_q;
    logic [WIDTH-1:0] rz_q;
    logic [WIDTH-1:0] ry_q;
    logic             unused_rin_c;

    // Slot IDX_C has no register behind it, so its load enable goes nowhere.
    assign unused_rin_c = Rin[IDX_C];

    assign mdr_d = MDRread ? Mdatain : bus_mux;

    genvar gi;
    generate
        for (gi = 0; gi < IDX_C; gi++) begin : g_bus_regs
            if (gi == IDX_MDR) begin : g_mdr
                reg32 #(.WIDTH(WIDTH)) u_reg (
                    .clock (clock),
                    .clear (clear),
                    .en_i  (Rin[gi]),
                    .d_i   (mdr_d),
                    .q_o   (src_q[gi])
                );
            end else begin : g_gpr
                reg32 #(.WIDTH(WIDTH)) u_reg (
                    .clock (clock),
                    .clear (clear),
                    .en_i  (Rin[gi]),
                    .d_i   (bus_mux),
                    .q_o   (src_q[gi])
                );
            end
        end
    endgenerate

    assign src_q[IDX_C] = {{(WIDTH-C_IMM_MSB-1){ir_q[C_IMM_MSB]}}, ir_q[C_IMM_MSB:0]};

    reg32 #(.WIDTH(WIDTH)) u_ir  (.clock(clock), .clear(clear), .en_i(IRin),  .d_i(bus_mux), .q_o(ir_q));
    reg32 #(.WIDTH(WIDTH)) u_mar (.clock(clock), .clear(clear), .en_i(MARin), .d_i(bus_mux), .q_o(mar_q));
    reg32 #(.WIDTH(WIDTH)) u_ra  (.clock(clock), .clear(clear), .en_i(RAin),  .d_i(A),       .q_o(ra_q));
    reg32 #(.WIDTH(WIDTH)) u_rb  (.clock(clock), .clear(clear), .en_i(RBin),  .d_i(B),       .q_o(rb_q));
    reg32 #(.WIDTH(WIDTH)) u_rc  (.clock(clock), .clear(clear), .en_i(RCin),  .d_i(bus_mux), .q_o(rc_q));
    reg32 #(.WIDTH(WIDTH)) u_rz  (.clock(clock), .clear(clear), .en_i(RZin),  .d_i(bus_mux), .q_o(rz_q));
    reg32 #(.WIDTH(WIDTH)) u_ry  (.clock(clock), .clear(clear), .en_i(RYin),  .d_i(bus_mux), .q_o(ry_q));

    // Later assignments win: lowest Rout index beats RA..RZ, which beat B.
    always_comb begin
        bus_mux = B;
        if (RZout) bus_mux = rz_q;
        if (RCout) bus_mux = rc_q;
        if (RBout) bus_mux = rb_q;
        if (RAout) bus_mux = ra_q;
        for (int i = NUM_SEL - 1; i >= 0; i--) begin
            if (Rout[i]) bus_mux = src_q[i];
        end
    end

    assign BusMuxOut = bus_mux;
    assign IRout     = ir_q;
    assign MARout    = mar_q;
    assign RYout     = ry_q;

endmodule

// File: tb/tb_bus_datapath.sv
// Directed, table-driven bench for bus_datapath with hand-computed bus values.
module tb_bus_datapath;

    localparam logic [11:0] K_IR  = 12'h001;
    localparam logic [11:0] K_MAR = 12'h002;
    localparam logic [11:0] K_RY  = 12'h004;
    localparam logic [11:0] K_RA  = 12'h008;
    localparam logic [11:0] K_RB  = 12'h010;
    localparam logic [11:0] K_RC  = 12'h020;
    localparam logic [11:0] K_RZ  = 12'h040;
    localparam logic [11:0] K_RAO = 12'h080;
    localparam logic [11:0] K_RBO = 12'h100;
    localparam logic [11:0] K_RCO = 12'h200;
    localparam logic [11:0] K_RZO = 12'h400;
    localparam logic [11:0] K_MRD = 12'h800;

    typedef struct {
        string       name;
        logic [23:0] rin;
        logic [23:0] rout;
        logic [11:0] ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] mdat;
        logic [31:0] exp_bus;
    } vec_t;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] A, B, Mdatain;
    logic [23:0] Rin, Rout;
    logic        IRin, MARin, RAout, RBout, RCout, RZout;
    logic        RYin, RAin, RBin, RCin, RZin, MDRread;
    logic [31:0] BusMuxOut, IRout, MARout, RYout;

    int pass_cnt  = 0;
    int total_cnt = 0;
    vec_t vecs[$];

    always #5 clock = ~clock;

    bus_datapath dut (
        .clock     (clock),
        .clear     (clear),
        .A         (A),
        .B         (B),
        .Mdatain   (Mdatain),
        .Rin       (Rin),
        .Rout      (Rout),
        .IRin      (IRin),
        .MARin     (MARin),
        .RAout     (RAout),
        .RBout     (RBout),
        .RCout     (RCout),
        .RZout     (RZout),
        .RYin      (RYin),
        .RAin      (RAin),
        .RBin      (RBin),
        .RCin      (RCin),
        .RZin      (RZin),
        .MDRread   (MDRread),
        .BusMuxOut (BusMuxOut),
        .IRout     (IRout),
        .MARout    (MARout),
        .RYout     (RYout)
    );

    function automatic logic [23:0] bit24(input int i);
        logic [23:0] one;
        one = 24'd1;
        return one << i;
    endfunction

    function automatic vec_t mk(input string nm, input logic [23:0] rin, input logic [23:0] rout,
                                input logic [11:0] ctl, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] m, input logic [31:0] exp_bus);
        vec_t v;
        v.name = nm; v.rin = rin; v.rout = rout; v.ctl = ctl;
        v.a = a; v.b = b; v.mdat = m; v.exp_bus = exp_bus;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic drive(input vec_t v, input logic clr);
        clear   = clr;
        Rin     = v.rin;
        Rout    = v.rout;
        A       = v.a;
        B       = v.b;
        Mdatain = v.mdat;
        IRin    = v.ctl[0];
        MARin   = v.ctl[1];
        RYin    = v.ctl[2];
        RAin    = v.ctl[3];
        RBin    = v.ctl[4];
        RCin    = v.ctl[5];
        RZin    = v.ctl[6];
        RAout   = v.ctl[7];
        RBout   = v.ctl[8];
        RCout   = v.ctl[9];
        RZout   = v.ctl[10];
        MDRread = v.ctl[11];
    endtask

    // Drive one cycle's controls, check the bus mid-cycle, then clock it in.
    task automatic apply(input vec_t v, input logic clr);
        drive(v, clr);
        #4;
        $display("txn %-14s clr=%0b rin=%06h rout=%06h ctl=%03h bus=%08h exp=%08h",
                 v.name, clr, v.rin, v.rout, v.ctl, BusMuxOut, v.exp_bus);
        check(v.name, BusMuxOut, v.exp_bus);
        @(posedge clock);
        #1;
    endtask

    initial begin
        vec_t idle;
        idle = mk("idle", '0, '0, '0, '0, '0, '0, '0);

        // Clear with every load enable high: clear must win.
        drive(mk("clear_all", 24'hFFFFFF, '0, 12'h07F, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, '0), 1'b1);
        @(posedge clock);
        #1;
        check("rst_irout",  IRout,  32'h0);
        check("rst_marout", MARout, 32'h0);
        check("rst_ryout",  RYout,  32'h0);

        vecs.push_back(mk("rst_r0",      bit24(0),  bit24(0),  '0, '0, 32'h12345678, '0, 32'h00000000));
        vecs.push_back(mk("rst_default", '0, '0, '0, '0, 32'h12345678, '0, 32'h12345678));
        vecs.push_back(mk("rst_inport",  '0, bit24(22), '0, '0, '0, '0, 32'h00000000));
        vecs.push_back(mk("rst_ra",      '0, '0, K_RAO, '0, 32'h1, '0, 32'h00000000));
        vecs.push_back(mk("mdr_mem",     bit24(21), '0, K_MRD, '0, 32'h0BAD0000, 32'hDEADBEEF, 32'h0BAD0000));
        vecs.push_back(mk("mdr_to_r5",   bit24(5), bit24(21), '0, '0, '0, '0, 32'hDEADBEEF));
        vecs.push_back(mk("r5_read",     '0, bit24(5), '0, '0, '0, '0, 32'hDEADBEEF));
        vecs.push_back(mk("mdr_bus",     bit24(21), '0, '0, '0, 32'h13572468, 32'hFFFFFFFF, 32'h13572468));
        vecs.push_back(mk("mdr_read",    '0, bit24(21), '0, '0, '0, '0, 32'h13572468));
        vecs.push_back(mk("ld_r0",       bit24(0),  '0, '0, '0, 32'h11111111, '0, 32'h11111111));
        vecs.push_back(mk("ld_r1",       bit24(1),  '0, '0, '0, 32'h22222222, '0, 32'h22222222));
        vecs.push_back(mk("ld_hi",       bit24(16), '0, '0, '0, 32'hDEADBEEF, '0, 32'hDEADBEEF));
        vecs.push_back(mk("ld_lo",       bit24(17), '0, '0, '0, 32'hCAFEBABE, '0, 32'hCAFEBABE));
        vecs.push_back(mk("ld_pc",       bit24(20), '0, '0, '0, 32'h00000002, '0, 32'h00000002));
        vecs.push_back(mk("ld_inport",   bit24(22), '0, '0, '0, 32'hAAAAAAAA, '0, 32'hAAAAAAAA));
        vecs.push_back(mk("rd_r0",       '0, bit24(0),  '0, '0, '0, '0, 32'h11111111));
        vecs.push_back(mk("rd_r1",       '0, bit24(1),  '0, '0, '0, '0, 32'h22222222));
        vecs.push_back(mk("rd_hi",       '0, bit24(16), '0, '0, '0, '0, 32'hDEADBEEF));
        vecs.push_back(mk("rd_lo",       '0, bit24(17), '0, '0, '0, '0, 32'hCAFEBABE));
        vecs.push_back(mk("rd_pc",       '0, bit24(20), '0, '0, '0, '0, 32'h00000002));
        vecs.push_back(mk("rd_inport",   '0, bit24(22), '0, '0, '0, '0, 32'hAAAAAAAA));
        vecs.push_back(mk("prio_r0_r1",  '0, bit24(0) | bit24(1), '0, '0, '0, '0, 32'h11111111));
        vecs.push_back(mk("ld_ir_neg",   '0, '0, K_IR, '0, 32'h0007FFFF, '0, 32'h0007FFFF));
        vecs.push_back(mk("cimm_neg",    '0, bit24(23), '0, '0, '0, '0, 32'hFFFFFFFF));
        vecs.push_back(mk("ld_ir_pos",   '0, '0, K_IR, '0, 32'h0003FFFF, '0, 32'h0003FFFF));
        vecs.push_back(mk("cimm_pos",    '0, bit24(23), '0, '0, '0, '0, 32'h0003FFFF));
        vecs.push_back(mk("ld_r4",       bit24(4), '0, '0, '0, 32'h11223344, '0, 32'h11223344));
        vecs.push_back(mk("ld_r5",       bit24(5), '0, '0, '0, 32'h55667788, '0, 32'h55667788));
        vecs.push_back(mk("ld_r6",       bit24(6), '0, '0, '0, 32'h99AABBCC, '0, 32'h99AABBCC));
        vecs.push_back(mk("ld_r7",       bit24(7), '0, '0, '0, 32'hDDEEFF00, '0, 32'hDDEEFF00));
        vecs.push_back(mk("rd_r4",       '0, bit24(4), '0, '0, '0, '0, 32'h11223344));
        vecs.push_back(mk("rd_r5",       '0, bit24(5), '0, '0, '0, '0, 32'h55667788));
        vecs.push_back(mk("rd_r6",       '0, bit24(6), '0, '0, '0, '0, 32'h99AABBCC));
        vecs.push_back(mk("rd_r7",       '0, bit24(7), '0, '0, '0, '0, 32'hDDEEFF00));
        vecs.push_back(mk("prio_r4_r7",  '0, bit24(4) | bit24(7), '0, '0, '0, '0, 32'h11223344));
        vecs.push_back(mk("ld_ra_rb",    '0, '0, K_RA | K_RB, 32'hCAFEF00D, 32'h0BADBEEF, '0, 32'h0BADBEEF));
        vecs.push_back(mk("rd_ra",       '0, '0, K_RAO, '0, '0, '0, 32'hCAFEF00D));
        vecs.push_back(mk("rd_rb",       '0, '0, K_RBO, '0, '0, '0, 32'h0BADBEEF));
        vecs.push_back(mk("prio_ra_rb",  '0, '0, K_RAO | K_RBO, '0, '0, '0, 32'hCAFEF00D));
        vecs.push_back(mk("ra_to_rz",    '0, '0, K_RAO | K_RZ, '0, '0, '0, 32'hCAFEF00D));
        vecs.push_back(mk("rd_rz",       '0, '0, K_RZO, '0, '0, '0, 32'hCAFEF00D));
        vecs.push_back(mk("prio_r4_ra",  '0, bit24(4), K_RAO, '0, '0, '0, 32'h11223344));
        vecs.push_back(mk("ld_ry",       '0, '0, K_RY, '0, 32'h00000005, '0, 32'h00000005));
        vecs.push_back(mk("r6_to_rc",    '0, bit24(6), K_RC, '0, '0, '0, 32'h99AABBCC));
        vecs.push_back(mk("rd_rc",       '0, '0, K_RCO, '0, '0, '0, 32'h99AABBCC));
        vecs.push_back(mk("prio_rc_rz",  '0, '0, K_RCO | K_RZO, '0, '0, '0, 32'h99AABBCC));
        vecs.push_back(mk("self_r4",     bit24(4), bit24(4), '0, '0, 32'h77777777, '0, 32'h11223344));
        vecs.push_back(mk("rd_r4_again", '0, bit24(4), '0, '0, '0, '0, 32'h11223344));
        vecs.push_back(mk("multi_ld",    bit24(8) | bit24(9), bit24(7), K_MAR, '0, '0, '0, 32'hDDEEFF00));
        vecs.push_back(mk("rd_r8",       '0, bit24(8), '0, '0, '0, '0, 32'hDDEEFF00));
        vecs.push_back(mk("rd_r9",       '0, bit24(9), '0, '0, '0, '0, 32'hDDEEFF00));
        vecs.push_back(mk("rin23_ignored", bit24(23), '0, '0, '0, 32'h77777777, '0, 32'h77777777));
        vecs.push_back(mk("cimm_kept",   '0, bit24(23), '0, '0, '0, '0, 32'h0003FFFF));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], 1'b0);
        end

        check("ryout",  RYout,  32'h00000005);
        check("marout", MARout, 32'hDDEEFF00);
        check("irout",  IRout,  32'h0003FFFF);

        // Clear does not gate the bus: with nothing selected it still shows B.
        apply(mk("clr_bus_b", 24'hFFFFFF, '0, 12'h07F, 32'hFFFFFFFF, 32'h5A5A5A5A, 32'hFFFFFFFF, 32'h5A5A5A5A), 1'b1);
        check("clr_irout",  IRout,  32'h0);
        check("clr_marout", MARout, 32'h0);
        check("clr_ryout",  RYout,  32'h0);
        apply(mk("clr_r5",   '0, bit24(5),  '0, '0, 32'h1, '0, 32'h0), 1'b0);
        apply(mk("clr_mdr",  '0, bit24(21), '0, '0, 32'h1, '0, 32'h0), 1'b0);
        apply(mk("clr_rz",   '0, '0, K_RZO, '0, 32'h1, '0, 32'h0), 1'b0);
        apply(mk("clr_rb",   '0, '0, K_RBO, '0, 32'h1, '0, 32'h0), 1'b0);
        apply(mk("clr_cimm", '0, bit24(23), '0, '0, 32'h1, '0, 32'h0), 1'b0);
        drive(idle, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
